// File: rtl/mod_div_param.sv
// mod_div_param: (a * b^-1) mod n for odd n via binary extended Euclid; ports i_clk, i_rst, i_start, i_abort, i_n, i_a, i_b, o_busy, o_valid, o_error, o_result
module mod_div_param #(
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(2*WIDTH)+1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_error,
    output logic [WIDTH-1:0] o_result
);
    typedef enum logic [2:0] {IDLE, CHECK, REDUCE, HALVE, FINAL, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] n, u, v, r, s, result;
    logic [CNT_W-1:0] cnt;
    logic err, chk_err;
    logic [WIDTH-1:0] r2, s2, rs, r_half;
    logic [WIDTH:0] r_odd;
    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, y, m);
        logic [WIDTH:0] t;
        t = {1'b0, x} + {1'b0, y};
        return (t >= {1'b0, m}) ? WIDTH'(t - {1'b0, m}) : t[WIDTH-1:0];
    endfunction
    always_comb begin
        r2 = mod_add(r, r, n);
        s2 = mod_add(s, s, n);
        rs = mod_add(r, s, n);
        r_odd = r[0] ? {1'b0, r} + {1'b0, n} : {1'b0, r};
        r_half = r_odd[WIDTH:1];
        chk_err = ~n[0] | (n < WIDTH'(3)) | (v == '0) | (s >= n) | (v >= n);
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   state_nx = i_start ? CHECK : IDLE;
            CHECK:  state_nx = chk_err ? DONE : REDUCE;
            REDUCE: state_nx = (v != '0) ? REDUCE : (u == WIDTH'(1)) ? HALVE : DONE;
            HALVE:  state_nx = (cnt <= CNT_W'(1)) ? FINAL : HALVE;
            FINAL:  state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (i_abort && state != IDLE) state_nx = IDLE;
    end
    always_comb begin
        o_busy = (state != IDLE) && (state != DONE);
        o_valid = state == DONE;
        o_error = o_valid & err;
        o_result = result;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            n <= '0;
            u <= '0;
            v <= '0;
            r <= '0;
            s <= '0;
            cnt <= '0;
            err <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    n <= i_n;
                    u <= i_n;
                    v <= i_b;
                    r <= '0;
                    s <= i_a;
                    cnt <= '0;
                end
                REDUCE: if (v != '0) begin
                    cnt <= cnt + 1'b1;
                    if (!u[0]) begin
                        u <= u >> 1;
                        s <= s2;
                    end else if (!v[0]) begin
                        v <= v >> 1;
                        r <= r2;
                    end else if (u > v) begin
                        u <= (u - v) >> 1;
                        r <= rs;
                        s <= s2;
                    end else begin
                        v <= (v - u) >> 1;
                        s <= rs;
                        r <= r2;
                    end
                end
                HALVE: if (cnt != '0) begin
                    r <= r_half;
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
            // only the CHECK/REDUCE error exits and FINAL enter DONE; abort never does
            if (state_nx == DONE) begin
                err <= state != FINAL;
                result <= (state == FINAL && r != '0) ? n - r : '0;
            end
        end
    end
endmodule

// File: tb/tb_mod_div_param.sv
// tb_mod_div_param: directed vector table plus corner sequences for mod_div_param at WIDTH=8
module tb_mod_div_param;
    logic i_clk, i_rst, i_start, i_abort;
    logic [7:0] i_n, i_a, i_b;
    logic o_busy, o_valid, o_error;
    logic [7:0] o_result;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [7:0] n, a, b;
        logic err;
        logic [7:0] res;
        int lat;
    } vec_t;
    vec_t vecs[16];
    mod_div_param #(.WIDTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_n(i_n), .i_a(i_a), .i_b(i_b),
        .o_busy(o_busy), .o_valid(o_valid), .o_error(o_error), .o_result(o_result)
    );
    initial i_clk = 0;
    always #5 i_clk = ~i_clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask
    // lat counts clock edges from the start-accepting edge to the edge that raises o_valid
    task automatic run_op(input logic [7:0] n, a, b, output int lat, output logic err, output logic [7:0] res);
        i_n = n;
        i_a = a;
        i_b = b;
        i_start = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        err = o_error;
        res = o_result;
        @(posedge i_clk); #1;
    endtask
    task automatic count_valids(input int cycles, output int cnt, output logic [7:0] res);
        cnt = 0;
        res = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                cnt++;
                res = o_result;
            end
        end
    endtask
    initial begin
        int lat, vc;
        logic err;
        logic [7:0] res;
        vecs[0]  = '{8'd11,  8'd1,   8'd3,   1'b0, 8'd4,   14};
        vecs[1]  = '{8'd13,  8'd5,   8'd7,   1'b0, 8'd10,  14};
        vecs[2]  = '{8'd13,  8'd0,   8'd7,   1'b0, 8'd0,   0};
        vecs[3]  = '{8'd12,  8'd1,   8'd5,   1'b1, 8'd0,   2};
        vecs[4]  = '{8'd11,  8'd1,   8'd0,   1'b1, 8'd0,   2};
        vecs[5]  = '{8'd15,  8'd1,   8'd5,   1'b1, 8'd0,   5};
        vecs[6]  = '{8'd1,   8'd0,   8'd0,   1'b1, 8'd0,   2};
        vecs[7]  = '{8'd11,  8'd11,  8'd3,   1'b1, 8'd0,   2};
        vecs[8]  = '{8'd11,  8'd1,   8'd11,  1'b1, 8'd0,   2};
        vecs[9]  = '{8'd251, 8'd17,  8'd200, 1'b0, 8'd167, 0};
        vecs[10] = '{8'd7,   8'd3,   8'd2,   1'b0, 8'd5,   0};
        vecs[11] = '{8'd255, 8'd1,   8'd2,   1'b0, 8'd128, 0};
        vecs[12] = '{8'd255, 8'd254, 8'd254, 1'b0, 8'd1,   0};
        vecs[13] = '{8'd9,   8'd3,   8'd3,   1'b1, 8'd0,   0};
        vecs[14] = '{8'd3,   8'd2,   8'd1,   1'b0, 8'd2,   0};
        vecs[15] = '{8'd2,   8'd1,   8'd1,   1'b1, 8'd0,   2};
        i_rst = 1;
        i_start = 0;
        i_abort = 0;
        i_n = 0;
        i_a = 0;
        i_b = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_outputs", {o_busy, o_valid, o_error, o_result}, 0);
        i_rst = 0;
        @(posedge i_clk); #1;
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].n, vecs[i].a, vecs[i].b, lat, err, res);
            chk($sformatf("vec%0d_err", i), err, vecs[i].err);
            chk($sformatf("vec%0d_res", i), res, vecs[i].res);
            if (vecs[i].lat != 0) chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            else chk($sformatf("vec%0d_lat_bound", i), lat <= 36, 1);
        end
        for (int i = 0; i < 20; i++) begin
            int a, b;
            a = $urandom_range(0, 250);
            b = $urandom_range(1, 250);
            run_op(8'd251, 8'(a), 8'(b), lat, err, res);
            chk($sformatf("rnd%0d_err", i), err, 0);
            chk($sformatf("rnd%0d_prod", i), (int'(res) * b) % 251, a);
        end
        run_op(8'd13, 8'd5, 8'd7, lat, err, res);
        i_n = 8'd251;
        i_a = 8'd17;
        i_b = 8'd200;
        i_start = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        repeat (4) @(posedge i_clk);
        #1;
        i_abort = 1;
        @(posedge i_clk); #1;
        i_abort = 0;
        chk("abort_busy_low", o_busy, 0);
        chk("abort_result_held", o_result, 10);
        count_valids(40, vc, res);
        chk("abort_no_valid", vc, 0);
        run_op(8'd251, 8'd17, 8'd200, lat, err, res);
        chk("restart_res", res, 167);
        i_n = 8'd7;
        i_a = 8'd3;
        i_b = 8'd2;
        i_start = 1;
        i_abort = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        i_abort = 0;
        chk("start_abort_idle_busy", o_busy, 1);
        count_valids(40, vc, res);
        chk("start_abort_idle_res", res, 5);
        i_n = 8'd13;
        i_a = 8'd5;
        i_b = 8'd7;
        i_start = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        repeat (3) @(posedge i_clk);
        #1;
        i_start = 1;
        i_n = 8'd11;
        i_a = 8'd2;
        i_b = 8'd3;
        @(posedge i_clk); #1;
        i_start = 0;
        count_valids(40, vc, res);
        chk("busy_start_one_valid", vc, 1);
        chk("busy_start_res", res, 10);
        run_op(8'd11, 8'd1, 8'd3, lat, err, res);
        chk("pre_reset_res", o_result, 4);
        i_start = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        repeat (3) @(posedge i_clk);
        #2;
        i_rst = 1;
        #1;
        chk("async_reset_outputs", {o_busy, o_valid, o_error, o_result}, 0);
        @(posedge i_clk); #1;
        i_rst = 0;
        count_valids(40, vc, res);
        chk("reset_no_valid", vc, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
